jtkunio_colmix: RTL

// Colour mixer downstream of the scroll and object layer generators. Each pixel
// it picks scroll or object colour by priority, then looks the index up in a
// CPU-writable palette RAM. It outputs 4-bit RGB with delayed blanking for the video output.

---
 rtl/jtkunio_colmix.sv | 113 +++++++++++
 1 files changed

// File: rtl/jtkunio_colmix.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtkunio_colmix : scroll/object priority mux, CPU palette RAM, RGB out    |
// | Optional macro JTKUNIO_LAYER_MASK_EN adds gfx_en[1:0] layer enables.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module jtkunio_colmix #(
  parameter int BLANK_DLY = 3
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
`ifdef JTKUNIO_LAYER_MASK_EN
  input  logic [1:0] gfx_en,
`endif
  input  logic [5:0] scr_pxl,
  input  logic [5:0] obj_pxl,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [8:0] cpu_addr,
  input  logic       pal_cs,
  input  logic       cpu_wrn,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  logic [7:0]           r_pal_lo [0:127];
  logic [7:0]           r_pal_hi [0:127];
  logic [7:0]           r_cpu_din;
  logic [6:0]           r_idx;
  logic [11:0]          r_pal_data;
  logic [11:0]          r_rgb;
  logic [BLANK_DLY-1:0] r_hbl;
  logic [BLANK_DLY-1:0] r_vbl;

  logic [6:0]           w_cpu_entry;
  logic                 w_cpu_we;
  logic                 w_obj_opaque;
  logic                 w_scr_en;
  logic [6:0]           w_idx;
  logic                 w_blank;
  logic                 w_unused;

  assign w_cpu_entry = cpu_addr[6:0];
  assign w_cpu_we    = pal_cs & ~cpu_wrn;
  assign w_unused    = cpu_addr[7];

`ifdef JTKUNIO_LAYER_MASK_EN
  assign w_obj_opaque = (obj_pxl[2:0] != 3'd0) & gfx_en[1];
  assign w_scr_en     = gfx_en[0];
`else
  assign w_obj_opaque = (obj_pxl[2:0] != 3'd0);
  assign w_scr_en     = 1'b1;
`endif

  always_comb begin
    w_idx = 7'h00;
    if (w_obj_opaque)
      w_idx = {1'b1, obj_pxl};
    else if (w_scr_en)
      w_idx = {1'b0, scr_pxl};
  end

  // Palette storage is not reset; the CPU owns its contents.
  always_ff @(posedge clk) begin
    if (w_cpu_we) begin
      if (cpu_addr[8])
        r_pal_hi[w_cpu_entry] <= cpu_dout;
      else
        r_pal_lo[w_cpu_entry] <= cpu_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cpu_din <= 8'h00;
    else
      r_cpu_din <= cpu_addr[8] ? r_pal_hi[w_cpu_entry] : r_pal_lo[w_cpu_entry];
  end

  // Blank for stage 3 uses the tap that LHBL_dly/LVBL_dly take on this same edge.
  assign w_blank = ~r_hbl[BLANK_DLY-2] | ~r_vbl[BLANK_DLY-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= 7'h00;
      r_pal_data <= 12'h000;
      r_rgb      <= 12'h000;
      r_hbl      <= '0;
      r_vbl      <= '0;
    end else if (pxl_cen) begin
      r_idx      <= w_idx;
      r_pal_data <= {r_pal_hi[r_idx][3:0], r_pal_lo[r_idx]};
      r_rgb      <= w_blank ? 12'h000 : r_pal_data;
      r_hbl      <= {r_hbl[BLANK_DLY-2:0], LHBL};
      r_vbl      <= {r_vbl[BLANK_DLY-2:0], LVBL};
    end
  end

  assign cpu_din  = r_cpu_din;
  assign red      = r_rgb[3:0];
  assign green    = r_rgb[7:4];
  assign blue     = r_rgb[11:8];
  assign LHBL_dly = r_hbl[BLANK_DLY-1];
  assign LVBL_dly = r_vbl[BLANK_DLY-1];

endmodule
`default_nettype wire
